// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes and arbiter FSM states shared by the ALU arbiter files.
package alu_pkg;
  localparam logic [2:0] ALU_SUB = 3'b000;
  localparam logic [2:0] ALU_MUL = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SHL = 3'b011;
  localparam logic [2:0] ALU_CMM = 3'b100;
  localparam logic [2:0] ALU_CME = 3'b101;
  localparam logic [2:0] ALU_CMP = 3'b110;
  localparam logic [2:0] ALU_ADD = 3'b111;
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU computing all eight op codes modulo 2^WIDTH.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  localparam int SW = $clog2(WIDTH);
  logic lt, eq;
  assign lt = $signed(a) < $signed(b);
  assign eq = a == b;
  always_comb begin
    y = a + b;
    case (op)
      ALU_SUB, ALU_CMP: y = a - b;
      ALU_MUL:          y = a * b;
      ALU_OR:           y = a | b;
      ALU_SHL:          y = a << b[SW-1:0];
      ALU_CMM:          y = {{(WIDTH-1){1'b0}}, lt};
      ALU_CME:          y = {{(WIDTH-1){1'b0}}, lt | eq};
      default:          y = a + b;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters,
// one op in flight, multiply as a fixed multicycle op, tagged response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             resp_neg
);
  localparam int CW = $clog2(MUL_LAT) + 1;
  state_t state, state_n;
  logic last_grant, g, acc, id_q, load;
  logic [CW-1:0] cnt;
  logic [2:0] op_q, op_g, op_c;
  logic [WIDTH-1:0] a_q, b_q, a_g, b_g, a_c, b_c, y;
  assign g          = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = rst_n & (state == IDLE) & req0_valid & ~g;
  assign req1_ready = rst_n & (state == IDLE) & req1_valid & g;
  assign acc        = req0_ready | req1_ready;
  assign op_g = g ? req1_op : req0_op;
  assign a_g  = g ? req1_a : req0_a;
  assign b_g  = g ? req1_b : req0_b;
  // single-cycle ops go straight from the request mux; MUL uses the captured copies
  assign op_c = (state == IDLE) ? op_g : op_q;
  assign a_c  = (state == IDLE) ? a_g : a_q;
  assign b_c  = (state == IDLE) ? b_g : b_q;
  alu_core #(.WIDTH(WIDTH)) u_core (.op(op_c), .a(a_c), .b(b_c), .y(y));
  assign load       = (acc & (op_g != ALU_MUL)) | ((state == MUL) & (cnt == '0));
  assign resp_valid = state == RESP;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = acc ? ((op_g == ALU_MUL) ? MUL : RESP) : IDLE;
      MUL:     state_n = (cnt == '0) ? RESP : MUL;
      default: state_n = resp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state <= state_n;
      if (acc) last_grant <= g;
      cnt <= acc ? CW'(MUL_LAT - 2) : ((state == MUL) && (cnt != '0)) ? cnt - 1'b1 : cnt;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
    end else if (acc) begin
      op_q <= op_g;
      a_q  <= a_g;
      b_q  <= b_g;
      id_q <= g;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data <= '0;
      resp_id   <= 1'b0;
      resp_zero <= 1'b0;
      resp_neg  <= 1'b0;
    end else if (load) begin
      resp_data <= y;
      resp_id   <= (state == IDLE) ? g : id_q;
      resp_zero <= y == '0;
      resp_neg  <= y[WIDTH-1];
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random requests scored against a reference ALU and arbitration model.
module tb_alu_arbiter;
  import alu_pkg::*;
  localparam int W = 32, LAT = 3;
  logic clk = 0, rst_n = 1;
  logic v0 = 0, v1 = 0, r0, r1, resp_ready = 1, resp_valid, resp_id, resp_zero, resp_neg;
  logic [2:0] op0 = 0, op1 = 0;
  logic [W-1:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0, resp_data;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  typedef struct {logic id; logic [W-1:0] data; int due;} exp_t;
  exp_t sbq[$];
  bit busy = 0, lg = 1, seen = 0, rand_rr = 0;
  logic g_exp, acc_id;
  logic [2:0] acc_op;
  always #5 clk = ~clk;
  alu_arbiter #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0), .req0_op(op0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(r1), .req1_op(op1), .req1_a(a1), .req1_b(b1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_neg(resp_neg)
  );
  function automatic logic [W-1:0] model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sv = longint'($signed(b));
    logic [63:0] p = 64'(a) * 64'(b);
    case (op)
      ALU_SUB, ALU_CMP: return a - b;
      ALU_MUL:          return p[W-1:0];
      ALU_OR:           return a | b;
      ALU_SHL:          return a << (b % W);
      ALU_CMM:          return W'(sa < sv);
      ALU_CME:          return W'(sa <= sv);
      default:          return a + b;
    endcase
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sbq.delete();
      busy = 0;
      lg = 1;
      seen = 0;
      chk("reset_outputs", {resp_valid, resp_id, resp_zero, resp_neg, r0, r1, resp_data}, 0);
    end else begin
      g_exp = (v0 && v1) ? !lg : v1;
      chk("ready", {r1, r0}, (busy || !(v0 || v1)) ? 2'b00 : (g_exp ? 2'b10 : 2'b01));
      if (resp_valid) begin
        if (sbq.size() == 0) chk("spurious_resp", resp_valid, 0);
        else begin
          if (!seen) begin
            chk("latency", cyc, sbq[0].due);
            seen = 1;
          end
          chk("resp", {resp_id, resp_zero, resp_neg, resp_data},
              {sbq[0].id, sbq[0].data == 0, sbq[0].data[W-1], sbq[0].data});
          if (resp_ready) begin
            void'(sbq.pop_front());
            busy = 0;
            seen = 0;
          end
        end
      end
      if ((v0 && r0) || (v1 && r1)) begin
        acc_id = r1;
        acc_op = acc_id ? op1 : op0;
        sbq.push_back('{acc_id, model(acc_op, acc_id ? a1 : a0, acc_id ? b1 : b0),
                        cyc + ((acc_op == ALU_MUL) ? LAT : 1)});
        busy = 1;
        lg = acc_id;
      end
    end
  end
  always @(posedge clk) if (rand_rr) #1 resp_ready = 1'($urandom_range(0, 1));
  task automatic set_req(bit p, bit v, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    if (p) begin v1 = v; op1 = op; a1 = a; b1 = b; end
    else begin v0 = v; op0 = op; a0 = a; b0 = b; end
  endtask
  task automatic issue(bit p, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    int t = 0;
    set_req(p, 1, op, a, b);
    do begin @(negedge clk); t++; end while (!(p ? r1 : r0) && t < 300);
    if (t >= 300) chk("accept_timeout", p ? r1 : r0, 1);
    @(posedge clk); #1;
    set_req(p, 0, op, a, b);
  endtask
  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 3))
      0: return W'($urandom_range(0, 40));
      1: return '1 - W'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction
  task automatic port_driver(bit p);
    for (int i = 0; i < 60; i++) begin
      issue(p, 3'($urandom_range(0, 7)), rnd(), rnd());
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
  endtask
  task automatic gap();
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t;
    rst_n = 0; v0 = 1; v1 = 1;
    repeat (3) @(negedge clk);
    v0 = 0; v1 = 0;
    @(posedge clk); #1 rst_n = 1;
    issue(0, ALU_ADD, 5, 7);
    gap();
    rst_n = 0;
    @(negedge clk); @(posedge clk); #1 rst_n = 1;
    fork
      issue(0, ALU_SUB, 3, 3);
      issue(1, ALU_OR, 'hF0, 'h0F);
    join
    issue(1, ALU_MUL, '1, 2);
    issue(0, ALU_CMM, '1, 1);
    issue(1, ALU_CME, 4, 4);
    issue(0, ALU_SHL, 1, 35);
    gap();
    resp_ready = 0;
    issue(0, ALU_ADD, 10, 20);
    fork
      issue(0, ALU_OR, 1, 2);
      begin repeat (6) @(posedge clk); #1 resp_ready = 1; end
    join
    gap();
    issue(1, ALU_MUL, 3, 4);
    rst_n = 0;
    set_req(1, 1, ALU_ADD, 1, 1);
    @(negedge clk); @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("first_cycle_accept", r1, 1);
    @(posedge clk); #1;
    set_req(1, 0, ALU_ADD, 1, 1);
    gap();
    rand_rr = 1;
    fork
      port_driver(0);
      port_driver(1);
    join
    rand_rr = 0;
    @(posedge clk); #2 resp_ready = 1;
    t = 0;
    while ((sbq.size() != 0 || busy) && t < 100) begin @(negedge clk); t++; end
    chk("drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
